mem_bus_loader: RTL and testbench
=================================

# mem_bus_loader

Serial-command bus initiator for the picorv32 native memory bus. It takes a byte stream, typically from the UART receive path, parses write, read and go commands, and issues single-word transactions to the same RAM/IO/UART responders the CPU uses. It returns response bytes on an outgoing stream. While `cpu_hold` is asserted it owns the bus, so firmware can be loaded and inspected before the CPU is released.

## Interface
Parameters:
- `TIMEOUT`, default 1024: number of cycles to wait for `mem_ready` before aborting; 2..65535.
- `HOLD_AT_RESET`, default 1: reset value of `cpu_hold`.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous reset, active-low.
- `in_valid`  in  1  command byte available.
- `in_data`  in  8  command byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `out_valid`  out  1  response byte available.
- `out_data`  out  8  response byte.
- `out_ready`  in  1  sink accepts the response byte.
- `mem_valid`  out  1  bus request.
- `mem_instr`  out  1  constant 0.
- `mem_ready`  in  1  responder completion.
- `mem_addr`  out  32  word address; bits [1:0] forced to 0.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  4'b1111 for a write, 4'b0000 for a read.
- `mem_rdata`  in  32  read data, valid in the cycle `mem_ready`=1.
- `cpu_hold`  out  1  1 = CPU must be held and the bus belongs to the loader (muxing is external).

## Operation
Byte transfers:
- An input byte transfers when `in_valid && in_ready`.
- An output byte transfers when `out_valid && out_ready`.
- Multi-byte fields are little-endian.

Commands:
- 0x57 'W': followed by 4 address bytes, then 4 data bytes. Performs a write and replies 0x4B 'K'.
- 0x52 'R': followed by 4 address bytes. Performs a read and replies with 4 data bytes, LSB first.
- 0x47 'G': clears `cpu_hold` and replies 'K'. No bus cycle.
- 0x48 'H': sets `cpu_hold` and replies 'K'. No bus cycle.
- Any other byte in IDLE: reply 0x3F '?' and stay in IDLE.

States and transitions:
- IDLE: decode the command byte.
- ADDR: collect 4 bytes.
- DATA: collect 4 bytes, writes only.
- BUS: transaction in progress.
- RESP: emit 1 or 4 bytes, then return to IDLE.

Input and output rules:
- `in_ready` = 1 only in IDLE, ADDR and DATA.
- No input is accepted in BUS or RESP; upstream buffers.

Bus rules:
- `mem_valid`, `mem_addr`, `mem_wdata` and `mem_wstrb` are registered and stay stable from assertion until the cycle `mem_ready`=1.
- `mem_valid` is 0 in the following cycle; there are no back-to-back requests.
- `mem_rdata` is captured into a 32-bit register on the `mem_ready` cycle.

Timeout:
- A 16-bit counter clears on entry to BUS and increments each BUS cycle while `mem_ready`=0.
- When the count reaches TIMEOUT-1 with `mem_ready` still 0, `mem_valid` drops next cycle and the response is the single byte 0x45 'E'.
- If `mem_ready`=1 in that same final cycle, success wins.

Commands are accepted while `cpu_hold`=0; bus safety is then the integrator's responsibility.

## Timing
Reset values (while `resetn`=0 and the cycle after):
- State is IDLE; `in_ready` is gated to 0 while `resetn`=0.
- `out_valid`=0, `mem_valid`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=HOLD_AT_RESET.

Latencies:
- `mem_valid` rises the cycle after the last address byte (R) or last data byte (W) is accepted.
- `out_valid` rises the cycle after the `mem_ready` cycle, or after timeout expiry.
- For '?', 'G' and 'H', `out_valid` rises the cycle after the command byte is accepted.
- `cpu_hold` changes in the same edge that raises `out_valid` for 'G' or 'H'.

Back-pressure:
- `out_data` is held while `out_valid && !out_ready`.
- The next byte is presented in the cycle after a transfer.
- After the final byte transfers, `in_ready`=1 in the next cycle.

Reset mid-operation:
- Abandons any command immediately; `mem_valid` drops at that edge with no completion wait.
- Partially received fields are discarded and `cpu_hold` returns to HOLD_AT_RESET.

Minimum write turnaround with always-ready peers: 9 input cycles + 1 request cycle + responder latency + 1 'K' cycle.

## Test plan
- Write/read-back against a 2-cycle-latency RAM model:
  - Send 57 10 00 00 00 EF BE AD DE. Require one bus write with addr 0x10, wdata 0xDEADBEEF, wstrb 1111, followed by reply 4B.
  - Send 52 10 00 00 00. Require wstrb 0000 and reply EF BE AD DE.
- Unaligned/unknown: send 52 13 00 00 00 and require `mem_addr`=0x10. Send 0x00 and require reply 3F with no bus activity.
- Timeout with TIMEOUT=8 and a responder that never completes:
  - Send an 'R' command. Require `mem_valid` high for exactly 8 cycles, then low, then reply 45.
  - Repeat with `mem_ready` pulsed in the 8th cycle. Require a data reply, not 'E'.
- Hold control: after reset `cpu_hold`=1. Send 47 and require 4B with `cpu_hold`=0 on that same edge. Send 48 and require `cpu_hold`=1.
- Back-pressure: during a read reply, hold `out_ready`=0 for 5 cycles per byte. Require each byte to stay stable, no bytes lost or duplicated, and `in_ready`=0 until the 4th byte transfers.
- Reset mid-operation: assert `resetn`=0 while `mem_valid`=1. Require `mem_valid`=0, `out_valid`=0 and `cpu_hold`=1 at the next edge. A subsequent full 'W' command must complete normally.

Source files
------------

// File: rtl/mem_bus_loader.sv
// Serial-command bus initiator: parses W/R/G/H byte commands and drives
// single-word transactions on the picorv32 native memory bus.
module mem_bus_loader #(
    parameter int unsigned TIMEOUT       = 1024,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        cpu_hold
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] resp_q, resp_d;       // reply bytes, LSB goes out first
    logic [2:0]  resp_left_q, resp_left_d;
    logic        out_valid_q, out_valid_d;
    logic        cpu_hold_q, cpu_hold_d;

    logic in_fire, out_fire;

    assign in_ready  = resetn && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = resp_q[7:0];
    assign mem_valid = mem_valid_q;
    assign mem_instr = 1'b0;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign cpu_hold  = cpu_hold_q;

    // Command parser, bus sequencing and reply generation.
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        tmo_d       = tmo_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        out_valid_d = out_valid_q;
        cpu_hold_d  = cpu_hold_q;
        unique case (state_q)
            S_IDLE: if (in_fire) begin
                cnt_d = 2'd0;
                case (in_data)
                    8'h57: begin is_wr_d = 1'b1; state_d = S_ADDR; end
                    8'h52: begin is_wr_d = 1'b0; state_d = S_ADDR; end
                    default: begin
                        // G/H/unknown all answer with a single byte, no bus cycle
                        state_d     = S_RESP;
                        out_valid_d = 1'b1;
                        resp_left_d = 3'd1;
                        resp_d      = {24'h0, 8'h3F};
                        if (in_data == 8'h47) begin
                            cpu_hold_d = 1'b0;
                            resp_d     = {24'h0, 8'h4B};
                        end else if (in_data == 8'h48) begin
                            cpu_hold_d = 1'b1;
                            resp_d     = {24'h0, 8'h4B};
                        end
                    end
                endcase
            end
            S_ADDR: if (in_fire) begin
                addr_d = {in_data, addr_q[31:8]};
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    if (is_wr_q) begin
                        state_d = S_DATA;
                    end else begin
                        state_d     = S_BUS;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {addr_d[31:2], 2'b00};
                        mem_wstrb_d = 4'b0000;
                        tmo_d       = 16'd0;
                    end
                end
            end
            S_DATA: if (in_fire) begin
                wdata_d = {in_data, wdata_q[31:8]};
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d     = S_BUS;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = {addr_q[31:2], 2'b00};
                    mem_wdata_d = wdata_d;
                    mem_wstrb_d = 4'b1111;
                    tmo_d       = 16'd0;
                end
            end
            S_BUS: begin
                // Completion takes priority over the final timeout cycle
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_RESP;
                    if (is_wr_q) begin
                        resp_d      = {24'h0, 8'h4B};
                        resp_left_d = 3'd1;
                    end else begin
                        resp_d      = mem_rdata;
                        resp_left_d = 3'd4;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    mem_valid_d = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_RESP;
                    resp_d      = {24'h0, 8'h45};
                    resp_left_d = 3'd1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_RESP: if (out_fire) begin
                if (resp_left_q == 3'd1) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    resp_d      = {8'h00, resp_q[31:8]};
                    resp_left_d = resp_left_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            cnt_q       <= 2'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
            tmo_q       <= 16'h0;
            resp_q      <= 32'h0;
            resp_left_q <= 3'd0;
            out_valid_q <= 1'b0;
            cpu_hold_q  <= HOLD_AT_RESET;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            tmo_q       <= tmo_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            out_valid_q <= out_valid_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_loader.sv
// Directed bench for mem_bus_loader with a small RAM responder model.
module tb_mem_bus_loader;

    logic        clk, resetn;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_data, out_data;
    logic        mem_valid, mem_instr, mem_ready, cpu_hold;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_bus_loader #(.TIMEOUT(8), .HOLD_AT_RESET(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .cpu_hold(cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: mode 0 = ready in 2nd request cycle, 1 = never, 2 = ready in 8th
    int          mode = 0;
    int          vcnt = 0;
    int          n_bus = 0;
    logic [31:0] ram [0:63];

    assign mem_ready = mem_valid && ((mode == 0 && vcnt == 1) || (mode == 2 && vcnt == 7));
    assign mem_rdata = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_valid && !mem_ready) vcnt <= vcnt + 1;
        else                         vcnt <= 0;
        if (mem_valid && mem_ready) begin
            n_bus <= n_bus + 1;
            if (mem_wstrb == 4'hF) ram[mem_addr[7:2]] <= mem_wdata;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte; returns at the negedge after it was accepted.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("send_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] a, input logic [31:0] d);
        send(8'h57);
        for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
    endtask

    task automatic send_r(input logic [31:0] a);
        send(8'h52);
        for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
    endtask

    // Take one reply byte with out_ready held high.
    task automatic recv(input string tag, input logic [7:0] exp);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk(tag, {23'h0, out_valid, out_data}, {23'h0, 1'b1, exp});
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_w;
        int          nb, n;
        logic        stable;
        resetn = 1'b0; in_valid = 1'b0; in_data = 8'h0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("mem_instr", 32'(mem_instr), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Write 0xDEADBEEF to 0x10
        nb = n_bus;
        send_w(32'h10, 32'hDEADBEEF);
        chk("w_valid", 32'(mem_valid), 32'd1);
        chk("w_addr", mem_addr, 32'h10);
        chk("w_wdata", mem_wdata, 32'hDEADBEEF);
        chk("w_wstrb", 32'(mem_wstrb), 32'hF);
        recv("w_K", 8'h4B);
        chk("w_bus_cnt", 32'(n_bus), 32'(nb + 1));
        chk("w_ram", ram[4], 32'hDEADBEEF);

        // Read it back
        send_r(32'h10);
        chk("r_valid", 32'(mem_valid), 32'd1);
        chk("r_wstrb", 32'(mem_wstrb), 32'h0);
        recv("r_b0", 8'hEF); recv("r_b1", 8'hBE); recv("r_b2", 8'hAD); recv("r_b3", 8'hDE);

        // Unaligned read is forced onto the word boundary
        send_r(32'h13);
        chk("ua_addr", mem_addr, 32'h10);
        recv("ua_b0", 8'hEF); recv("ua_b1", 8'hBE); recv("ua_b2", 8'hAD); recv("ua_b3", 8'hDE);

        // Unknown command
        nb = n_bus;
        send(8'h00);
        chk("unk_out_valid", 32'(out_valid), 32'd1);
        chk("unk_mem_valid", 32'(mem_valid), 32'd0);
        recv("unk_q", 8'h3F);
        chk("unk_bus_cnt", 32'(n_bus), 32'(nb));

        // Timeout: responder never completes
        mode = 1;
        send_r(32'h20);
        n = 0;
        while (mem_valid && n < 50) begin n++; @(negedge clk); end
        chk("tmo_cycles", 32'(n), 32'd8);
        chk("tmo_out_valid", 32'(out_valid), 32'd1);
        recv("tmo_E", 8'h45);

        // Completion in the final timeout cycle wins
        mode = 0;
        send_w(32'h24, 32'h12345678);
        recv("w2_K", 8'h4B);
        mode = 2;
        send_r(32'h24);
        n = 0;
        while (mem_valid && n < 50) begin n++; @(negedge clk); end
        chk("late_cycles", 32'(n), 32'd8);
        recv("late_b0", 8'h78); recv("late_b1", 8'h56); recv("late_b2", 8'h34); recv("late_b3", 8'h12);
        mode = 0;

        // Hold control
        chk("hold_init", 32'(cpu_hold), 32'd1);
        send(8'h47);
        chk("go_out_valid", 32'(out_valid), 32'd1);
        chk("go_hold", 32'(cpu_hold), 32'd0);
        recv("go_K", 8'h4B);
        send(8'h48);
        chk("halt_out_valid", 32'(out_valid), 32'd1);
        chk("halt_hold", 32'(cpu_hold), 32'd1);
        recv("halt_K", 8'h4B);

        // Back-pressure on a read reply
        exp_w = 32'hDEADBEEF;
        send_r(32'h10);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!out_valid && n < 100) begin @(negedge clk); n++; end
            stable = 1'b1;
            for (int k = 0; k < 5; k++) begin
                if (!out_valid || out_data !== exp_w[8*i +: 8] || in_ready) stable = 1'b0;
                @(negedge clk);
            end
            chk("bp_stable", 32'(stable), 32'd1);
            chk("bp_byte", {23'h0, out_valid, out_data}, {23'h0, 1'b1, exp_w[8*i +: 8]});
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("bp_in_ready", 32'(in_ready), 32'd1);
        chk("bp_no_extra", 32'(out_valid), 32'd0);

        // Reset mid-transaction
        send(8'h47);
        recv("rm_go_K", 8'h4B);
        mode = 1;
        send_r(32'h20);
        chk("rm_valid_pre", 32'(mem_valid), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("rm_mem_valid", 32'(mem_valid), 32'd0);
        chk("rm_out_valid", 32'(out_valid), 32'd0);
        chk("rm_hold", 32'(cpu_hold), 32'd1);
        chk("rm_in_ready", 32'(in_ready), 32'd0);
        resetn = 1'b1;
        mode = 0;
        @(negedge clk);
        send_w(32'h30, 32'hCAFEF00D);
        chk("rm_w_addr", mem_addr, 32'h30);
        chk("rm_w_wdata", mem_wdata, 32'hCAFEF00D);
        recv("rm_w_K", 8'h4B);
        send_r(32'h30);
        recv("rm_r_b0", 8'h0D); recv("rm_r_b1", 8'hF0); recv("rm_r_b2", 8'hFE); recv("rm_r_b3", 8'hCA);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
